sprite_blitter: RTL and testbench

Reader side of the sprite ROMs. It walks a rectangular sprite stored row-major in a synchronous sprite ROM. The ROM's address is captured on the clock and its q is valid the next cycle. Each pixel is emitted as a plot request to the VGA/framebuffer writer; transparent pixels and off-screen pixels are skipped. It sits between the game logic, which issues draw requests, and the VGA adapter plot port.

---
 rtl/sprite_blitter.sv | 152 +++++++++++++++
 tb/tb_sprite_blitter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Walks a row-major sprite in a synchronous ROM and issues clipped, non-transparent plot requests.
// Optional horizontal mirroring is enabled by defining SPRITE_FLIP_EN (adds the flip_x input).
module sprite_blitter #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned COLOR_W     = 3,
    parameter int unsigned DIM_W       = 5,
    parameter int unsigned X_W         = 8,
    parameter int unsigned Y_W         = 7,
    parameter int unsigned SCREEN_W    = 160,
    parameter int unsigned SCREEN_H    = 120,
    parameter int unsigned TRANSPARENT = 0
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic [ADDR_W-1:0]  sprite_base,
    input  logic [DIM_W-1:0]   sprite_w,
    input  logic [DIM_W-1:0]   sprite_h,
    input  logic [X_W-1:0]     pos_x,
    input  logic [Y_W-1:0]     pos_y,
`ifdef SPRITE_FLIP_EN
    input  logic               flip_x,
`endif
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [COLOR_W-1:0] rom_q,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COLOR_W-1:0] vga_colour,
    output logic               vga_plot,
    input  logic               fb_ready,
    output logic               busy,
    output logic               done
);

    localparam logic [X_W:0]       ScreenW = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]       ScreenH = (Y_W+1)'(SCREEN_H);
    localparam logic [COLOR_W-1:0] Transp  = COLOR_W'(TRANSPARENT);

    typedef enum logic [2:0] {StIdle, StFetch, StData, StWrite, StDone} state_e;

    state_e             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DIM_W-1:0]   w_q, h_q, col_q, row_q;
    logic [X_W-1:0]     pos_x_q, vga_x_q;
    logic [Y_W-1:0]     pos_y_q, vga_y_q;
    logic [COLOR_W-1:0] colour_q;
`ifdef SPRITE_FLIP_EN
    logic               flip_q;
`endif

    logic [DIM_W-1:0] col_off, col_adv, row_adv;
    logic [X_W:0]     sx;
    logic [Y_W:0]     sy;
    logic             last_col, last_px, skip_px;

    always_comb begin
        col_off = col_q;
`ifdef SPRITE_FLIP_EN
        if (flip_q) col_off = w_q - DIM_W'(1) - col_q;
`endif
        sx       = {1'b0, pos_x_q} + (X_W+1)'(col_off);
        sy       = {1'b0, pos_y_q} + (Y_W+1)'(row_q);
        last_col = (col_q == w_q - DIM_W'(1));
        last_px  = last_col && (row_q == h_q - DIM_W'(1));
        col_adv  = last_col ? '0 : col_q + DIM_W'(1);
        row_adv  = last_col ? row_q + DIM_W'(1) : row_q;
        skip_px  = (rom_q == Transp) || (sx >= ScreenW) || (sy >= ScreenH);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            w_q      <= '0;
            h_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            vga_x_q  <= '0;
            vga_y_q  <= '0;
            colour_q <= '0;
`ifdef SPRITE_FLIP_EN
            flip_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        w_q     <= sprite_w;
                        h_q     <= sprite_h;
                        pos_x_q <= pos_x;
                        pos_y_q <= pos_y;
                        col_q   <= '0;
                        row_q   <= '0;
`ifdef SPRITE_FLIP_EN
                        flip_q  <= flip_x;
`endif
                        // Empty sprites never touch the ROM address.
                        if (sprite_w == '0 || sprite_h == '0) begin
                            state_q <= StDone;
                        end else begin
                            addr_q  <= sprite_base;
                            state_q <= StFetch;
                        end
                    end
                end
                StFetch: state_q <= StData;
                StData: begin
                    if (skip_px) begin
                        if (last_px) begin
                            state_q <= StDone;
                        end else begin
                            col_q   <= col_adv;
                            row_q   <= row_adv;
                            addr_q  <= addr_q + ADDR_W'(1);
                            state_q <= StFetch;
                        end
                    end else begin
                        vga_x_q  <= sx[X_W-1:0];
                        vga_y_q  <= sy[Y_W-1:0];
                        colour_q <= rom_q;
                        state_q  <= StWrite;
                    end
                end
                StWrite: begin
                    if (fb_ready) begin
                        if (last_px) begin
                            state_q <= StDone;
                        end else begin
                            col_q   <= col_adv;
                            row_q   <= row_adv;
                            addr_q  <= addr_q + ADDR_W'(1);
                            state_q <= StFetch;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rom_address = addr_q;
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_colour  = colour_q;
    assign vga_plot    = (state_q == StWrite);
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomised and directed bench for sprite_blitter against a pixel-list reference model.
// Define SPRITE_FLIP_EN for both bench and design to exercise mirroring.
module tb_sprite_blitter;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] sprite_base;
    logic [4:0] sprite_w, sprite_h;
    logic [7:0] pos_x;
    logic [6:0] pos_y;
    logic       flip_x;
    logic [7:0] rom_address;
    logic [2:0] rom_q;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, fb_ready, busy, done;

    logic [2:0] rom [256];
    int         errors = 0;
    int         checks = 0;
    int         last_addr = 0;

    sprite_blitter dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .sprite_base (sprite_base),
        .sprite_w    (sprite_w),
        .sprite_h    (sprite_h),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
`ifdef SPRITE_FLIP_EN
        .flip_x      (flip_x),
`endif
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .fb_ready    (fb_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_q <= rom[rom_address];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_draw(input int base, input int w, input int h, input int px, input int py,
                            input int fl, input int stall_max, input int stall0);
        int exp_plot[$];
        int stalls[$];
        int addr_exp[$];
        int addr_got[$];
        int exp_cycles, pi, wait_n, done_cyc, busy_bad, extra, got;
        exp_cycles = 1;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int a, col, sx, sy, st;
                a   = (base + r * w + c) % 256;
                col = int'(rom[a]);
                sx  = px + ((fl != 0) ? (w - 1 - c) : c);
                sy  = py + r;
                addr_exp.push_back(a);
                if (col != 0 && sx < 160 && sy < 120) begin
                    st = (exp_plot.size() == 0 && stall0 >= 0) ? stall0
                                                               : $urandom_range(stall_max, 0);
                    exp_plot.push_back((sx << 16) | (sy << 8) | col);
                    stalls.push_back(st);
                    exp_cycles += 3 + st;
                end else begin
                    exp_cycles += 2;
                end
            end
        end
        if (addr_exp.size() > 0) last_addr = addr_exp[$];

        @(negedge clock);
        sprite_base = 8'(base);
        sprite_w    = 5'(w);
        sprite_h    = 5'(h);
        pos_x       = 8'(px);
        pos_y       = 7'(py);
        flip_x      = 1'(fl);
        start       = 1'b1;
        fb_ready    = 1'b0;
        pi = 0; wait_n = 0; done_cyc = -1; busy_bad = 0; extra = 0;
        for (int n = 1; n <= exp_cycles + 40; n++) begin
            @(negedge clock);
            if (n == 1 || n == 4) start = 1'b0;
            if (!busy) busy_bad++;
            if (busy && !done && (addr_got.size() == 0 || addr_got[$] != int'(rom_address)))
                addr_got.push_back(int'(rom_address));
            if (vga_plot) begin
                if (pi < exp_plot.size()) begin
                    got = (int'(vga_x) << 16) | (int'(vga_y) << 8) | int'(vga_colour);
                    check_val("plot_xyc", got, exp_plot[pi]);
                    if (wait_n < stalls[pi]) begin
                        fb_ready = 1'b0;
                        wait_n++;
                    end else begin
                        fb_ready = 1'b1;
                        pi++;
                        wait_n = 0;
                    end
                end else begin
                    extra++;
                    fb_ready = 1'b1;
                end
            end else begin
                fb_ready = 1'($urandom);
            end
            if (done) begin
                done_cyc = n;
                check_val("addr_hold", rom_address, last_addr);
                break;
            end
            if (n == 3) begin
                // Start during a draw must be ignored, whatever the inputs say.
                start       = 1'b1;
                sprite_base = 8'($urandom);
                sprite_w    = 5'($urandom);
                sprite_h    = 5'($urandom);
                pos_x       = 8'($urandom);
                pos_y       = 7'($urandom);
                flip_x      = 1'($urandom);
            end
        end
        start = 1'b0;
        check_val("done_cycle", done_cyc, exp_cycles);
        check_val("busy_during", busy_bad, 0);
        check_val("plot_count", pi + extra, exp_plot.size());
        check_val("addr_count", addr_got.size(), addr_exp.size());
        for (int i = 0; i < addr_got.size() && i < addr_exp.size(); i++)
            check_val("addr_seq", addr_got[i], addr_exp[i]);
        @(negedge clock);
        check_val("idle_after", {busy, done, vga_plot}, 3'b000);
    endtask

    initial begin
        int found;
        int fl;
        for (int i = 0; i < 256; i++) rom[i] = 3'($urandom);
        resetn = 1'b0; start = 1'b0; fb_ready = 1'b0; flip_x = 1'b0;
        sprite_base = '0; sprite_w = '0; sprite_h = '0; pos_x = '0; pos_y = '0;
        repeat (3) @(negedge clock);
        check_val("reset_outs", {vga_plot, busy, done, rom_address, vga_x, vga_y, vga_colour}, 0);
        resetn = 1'b1;
        @(negedge clock);

        rom[10] = 3'd1; rom[11] = 3'd2; rom[12] = 3'd0; rom[13] = 3'd3;
        run_draw(10, 2, 2, 5, 7, 0, 0, 0);
        run_draw(10, 2, 2, 5, 7, 0, 0, 4);
        run_draw(254, 4, 1, 20, 20, 0, 1, -1);
        for (int i = 0; i < 256; i++) rom[i] = 3'($urandom_range(7, 1));
        run_draw(40, 3, 2, 158, 119, 0, 0, 0);
        run_draw(60, 0, 3, 10, 10, 0, 0, 0);
        run_draw(60, 3, 0, 10, 10, 0, 0, 0);
`ifdef SPRITE_FLIP_EN
        rom[80] = 3'd1; rom[81] = 3'd2;
        run_draw(80, 2, 1, 5, 7, 1, 0, 0);
`endif

        // Asynchronous reset while a plot is pending.
        @(negedge clock);
        sprite_base = 8'd100; sprite_w = 5'd3; sprite_h = 5'd2;
        pos_x = 8'd30; pos_y = 7'd30; flip_x = 1'b0; start = 1'b1; fb_ready = 1'b0;
        found = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            start = 1'b0;
            fb_ready = 1'b0;
            if (vga_plot) begin
                found = 1;
                break;
            end
        end
        check_val("reached_write", found, 1);
        #2 resetn = 1'b0;
        #1 check_val("rst_mid_draw", {vga_plot, busy, done, rom_address, vga_x}, 0);
        fb_ready = 1'b1;
        repeat (2) @(negedge clock);
        check_val("rst_held", {vga_plot, busy, done}, 3'b000);
        resetn = 1'b1;
        last_addr = 0;
        run_draw(100, 3, 2, 30, 30, 0, 2, -1);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 256; i++) rom[i] = 3'($urandom);
`ifdef SPRITE_FLIP_EN
            fl = int'($urandom_range(1, 0));
`else
            fl = 0;
`endif
            run_draw(int'($urandom_range(255, 0)), int'($urandom_range(6, 0)),
                     int'($urandom_range(5, 0)),
                     ((t % 3) == 0) ? int'($urandom_range(255, 0)) : int'($urandom_range(165, 150)),
                     int'($urandom_range(127, 110)), fl, 3, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
